// File: rtl/universal_shifter.sv
// Multi-cycle universal shifter: one 1-bit step per clock over a 2*Word_Length register.
// Define SHIFTER_ROTATE_EN to build the rotate-left datapath for Mode=11.
module universal_shifter #(
  parameter int unsigned Word_Length  = 8,
  localparam int unsigned Data_Width  = 2 * Word_Length,
  parameter int unsigned Amount_Width = $clog2(2 * Word_Length) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    Start,
  input  logic                    Abort,
  input  logic [1:0]              Mode,
  input  logic [Amount_Width-1:0] Shift_Amount,
  input  logic [Data_Width-1:0]   Data_Input,
  output logic [Data_Width-1:0]   Data_Output,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Carry_Out
);

  localparam logic [Amount_Width-1:0] MaxAmt = Amount_Width'(Data_Width);
  localparam logic [Amount_Width-1:0] OneAmt = Amount_Width'(1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e                  state_q, state_d;
  logic [Data_Width-1:0]   data_q, data_d;
  logic [Amount_Width-1:0] count_q, count_d;
  logic [1:0]              mode_q, mode_d;
  logic                    carry_q, carry_d;

  logic [Data_Width-1:0]   step_data;
  logic                    step_carry;

  // Single 1-bit step of the captured mode applied to the current register.
  always_comb begin
    step_data  = data_q;
    step_carry = carry_q;
    case (mode_q)
      2'b00: begin
        step_data  = {data_q[Data_Width-2:0], 1'b0};
        step_carry = data_q[Data_Width-1];
      end
      2'b01: begin
        step_data  = {1'b0, data_q[Data_Width-1:1]};
        step_carry = data_q[0];
      end
      2'b10: begin
        step_data  = {data_q[Data_Width-1], data_q[Data_Width-1:1]};
        step_carry = data_q[0];
      end
      2'b11: begin
`ifdef SHIFTER_ROTATE_EN
        step_data  = {data_q[Data_Width-2:0], data_q[Data_Width-1]};
`else
        step_data  = {data_q[Data_Width-2:0], 1'b0};
`endif
        step_carry = data_q[Data_Width-1];
      end
      default: begin
        step_data  = data_q;
        step_carry = carry_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    mode_d  = mode_q;
    carry_d = carry_q;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          data_d  = Data_Input;
          mode_d  = Mode;
          count_d = (Shift_Amount > MaxAmt) ? MaxAmt : Shift_Amount;
          carry_d = 1'b0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (count_q != '0) begin
          data_d  = step_data;
          carry_d = step_carry;
          count_d = count_q - OneAmt;
        end
        // The step on the abort edge still lands; only the completion is suppressed.
        if (Abort) begin
          count_d = '0;
          state_d = StIdle;
        end else if (count_q <= OneAmt) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      data_q  <= '0;
      count_q <= '0;
      mode_q  <= 2'b00;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      carry_q <= carry_d;
    end
  end

  assign Data_Output = data_q;
  assign Carry_Out   = carry_q;
  assign Busy        = (state_q == StShift);
  assign Done        = (state_q == StDone);

  busy_done_exclusive_a : assert property (@(posedge clk) disable iff (!reset) !(Busy && Done));
  done_single_cycle_a   : assert property (@(posedge clk) disable iff (!reset) Done |=> !Done);

endmodule

// File: tb/tb_universal_shifter.sv
// Self-checking bench for universal_shifter (Word_Length=8): closed-form model plus directed cases.
module tb_universal_shifter;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic        Abort;
  logic [1:0]  Mode;
  logic [4:0]  Shift_Amount;
  logic [15:0] Data_Input;
  logic [15:0] Data_Output;
  logic        Busy;
  logic        Done;
  logic        Carry_Out;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  universal_shifter dut (
    .clk         (clk),
    .reset       (reset),
    .Start       (Start),
    .Abort       (Abort),
    .Mode        (Mode),
    .Shift_Amount(Shift_Amount),
    .Data_Input  (Data_Input),
    .Data_Output (Data_Output),
    .Busy        (Busy),
    .Done        (Done),
    .Carry_Out   (Carry_Out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Register value after n steps from d, in closed form.
  function automatic logic [15:0] f_data(input logic [15:0] d, input logic [1:0] m, input int n);
    if (n == 0) return d;
    case (m)
      2'd0: return d << n;
      2'd1: return d >> n;
      2'd2: return 16'($signed(d) >>> n);
`ifdef SHIFTER_ROTATE_EN
      default: return (d << n) | (d >> (16 - n));
`else
      default: return d << n;
`endif
    endcase
  endfunction

  function automatic logic f_carry(input logic [15:0] d, input logic [1:0] m, input int n);
    if (n == 0) return 1'b0;
    if (m == 2'd1 || m == 2'd2) return d[n-1];
    return d[16-n];
  endfunction

  bit          m_active = 1'b0;
  bit          m_done = 1'b0;
  int          m_n = 0;
  int          m_k = 0;
  int          m_s = 0;
  logic [15:0] m_d0 = '0;
  logic [15:0] m_data = '0;
  logic [1:0]  m_mode = '0;
  logic        m_carry = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_n      = 0;
      m_data   = '0;
      m_carry  = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_active) begin
      m_n++;
      if (Abort) begin
        m_active = 1'b0;
        m_s      = (m_n < m_k) ? m_n : m_k;
      end else if (m_n >= ((m_k > 0) ? m_k : 1)) begin
        m_active = 1'b0;
        m_done   = 1'b1;
        m_s      = m_k;
      end else begin
        m_s = m_n;
      end
      if (m_s > 0) begin
        m_data  = f_data(m_d0, m_mode, m_s);
        m_carry = f_carry(m_d0, m_mode, m_s);
      end
    end else if (Start) begin
      m_active = 1'b1;
      m_n      = 0;
      m_d0     = Data_Input;
      m_mode   = Mode;
      m_k      = (Shift_Amount > 5'd16) ? 16 : int'(Shift_Amount);
      m_data   = Data_Input;
      m_carry  = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_data", {16'h0, Data_Output}, {16'h0, m_data});
      chk("cyc_carry", {31'h0, Carry_Out}, {31'h0, m_carry});
      chk("cyc_busy", {31'h0, Busy}, {31'h0, m_active});
      chk("cyc_done", {31'h0, Done}, {31'h0, m_done});
    end
  end

  // Issue one operation and follow it to completion; scrambles inputs after E0.
  task automatic run_op(input logic [15:0] d, input logic [1:0] m, input logic [4:0] a,
                        output int busy_n, output int done_n);
    Data_Input   = d;
    Mode         = m;
    Shift_Amount = a;
    Start        = 1'b1;
    @(posedge clk);
    #2;
    Start        = 1'b0;
    Data_Input   = 16'($urandom);
    Mode         = 2'($urandom);
    Shift_Amount = 5'($urandom);
    busy_n = 0;
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (Busy) busy_n++;
      if (Done) done_n++;
      if (!Busy && !Done) break;
    end
    chk("op_complete", {31'h0, Busy | Done}, 32'h0);
  endtask

  int bn, dn;

  initial begin
    reset        = 1'b0;
    Start        = 1'b0;
    Abort        = 1'b0;
    Mode         = 2'b00;
    Shift_Amount = '0;
    Data_Input   = '0;
    #1;
    chk("rst_data", {16'h0, Data_Output}, 32'h0);
    chk("rst_busy", {31'h0, Busy}, 32'h0);
    chk("rst_done", {31'h0, Done}, 32'h0);
    chk("rst_carry", {31'h0, Carry_Out}, 32'h0);
    cmp_en = 1'b1;
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);

    run_op(16'h00AA, 2'b00, 5'd3, bn, dn);
    chk("ll3_data", {16'h0, Data_Output}, 32'h0550);
    chk("ll3_carry", {31'h0, Carry_Out}, 32'h0);
    chk("ll3_busy_cycles", bn, 3);
    chk("ll3_done_cycles", dn, 1);

    run_op(16'h8001, 2'b10, 5'd4, bn, dn);
    chk("ar4_data", {16'h0, Data_Output}, 32'hF800);
    chk("ar4_carry", {31'h0, Carry_Out}, 32'h0);

    run_op(16'h8001, 2'b10, 5'd20, bn, dn);
    chk("ar20_data", {16'h0, Data_Output}, 32'hFFFF);
    chk("ar20_busy_cycles", bn, 16);

    run_op(16'hFFFF, 2'b01, 5'd31, bn, dn);
    chk("lr31_data", {16'h0, Data_Output}, 32'h0);
    chk("lr31_carry", {31'h0, Carry_Out}, 32'h1);

    run_op(16'h8001, 2'b11, 5'd1, bn, dn);
`ifdef SHIFTER_ROTATE_EN
    chk("m11_data", {16'h0, Data_Output}, 32'h0003);
`else
    chk("m11_data", {16'h0, Data_Output}, 32'h0002);
`endif
    chk("m11_carry", {31'h0, Carry_Out}, 32'h1);

    run_op(16'hC000, 2'b00, 5'd2, bn, dn);
    chk("ll2_data", {16'h0, Data_Output}, 32'h0);
    chk("ll2_carry", {31'h0, Carry_Out}, 32'h1);

    run_op(16'h1234, 2'b00, 5'd0, bn, dn);
    chk("amt0_data", {16'h0, Data_Output}, 32'h1234);
    chk("amt0_busy_cycles", bn, 1);
    chk("amt0_done_cycles", dn, 1);

    // Abort after E2; a Start sampled at E2 while shifting must be ignored.
    Data_Input   = 16'h00FF;
    Mode         = 2'b01;
    Shift_Amount = 5'd8;
    Start        = 1'b1;
    @(posedge clk);
    #2 Start = 1'b0;
    @(posedge clk);
    #2;
    Start      = 1'b1;
    Data_Input = 16'hFFFF;
    @(posedge clk);
    #2;
    Start = 1'b0;
    Abort = 1'b1;
    @(posedge clk);
    #2 Abort = 1'b0;
    @(negedge clk);
    chk("abort_data", {16'h0, Data_Output}, 32'h001F);
    chk("abort_busy", {31'h0, Busy}, 32'h0);
    chk("abort_done", {31'h0, Done}, 32'h0);
    @(negedge clk);
    chk("abort_no_done", {31'h0, Done}, 32'h0);

    // Abort while idle is a no-op.
    Abort = 1'b1;
    @(negedge clk);
    Abort = 1'b0;
    chk("idle_abort_data", {16'h0, Data_Output}, 32'h001F);

    // Asynchronous reset in the middle of SHIFT.
    Data_Input   = 16'h00AA;
    Mode         = 2'b00;
    Shift_Amount = 5'd3;
    Start        = 1'b1;
    @(posedge clk);
    #2 Start = 1'b0;
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("midrst_data", {16'h0, Data_Output}, 32'h0);
    chk("midrst_busy", {31'h0, Busy}, 32'h0);
    chk("midrst_done", {31'h0, Done}, 32'h0);
    chk("midrst_carry", {31'h0, Carry_Out}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);

    run_op(16'h00AA, 2'b00, 5'd3, bn, dn);
    chk("post_rst_data", {16'h0, Data_Output}, 32'h0550);
    chk("post_rst_done_cycles", dn, 1);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
